ps2_kbd_fifo: RTL and testbench

- Sits directly downstream of the PS/2 driver.
- Consumes the driver's ASCII byte and level interrupt request. Acknowledges each byte with a req/ack handshake and buffers bytes in a first-word-fall-through FIFO.
- Exposes a simple pop interface plus a level interrupt for the CPU bus side.
- Applies backpressure to the driver when full; no keystroke is silently lost.

---
 rtl/ps2_kbd_fifo.sv | 134 +++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo.sv
// Keyboard byte buffer: takes bytes from the PS/2 driver over a req/ack handshake
// and presents them to the CPU through a first-word-fall-through FIFO.
module ps2_kbd_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter bit DROP_ZERO  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_key,
   input  logic [7:0]            kbd_ascii,
   input  logic                  kbd_int_req,
   output logic                  kbd_int_ack,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic                  cpu_irq,
   output logic [DEPTH_LOG2:0]   count,
   input  logic                  clr,
   output logic                  dbg_state_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic [7:0]              rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;

   logic                    full;
   logic                    capture;
   logic                    store;
   logic                    wr_en;
   logic                    pop;

   // Handshake: the driver raises kbd_int_req with kbd_ascii stable and holds both
   // until kbd_int_ack=1; it then drops req, and ack falls on the following edge.
   // A capture happens only in IDLE, so one req assertion yields at most one byte.
   assign full    = (count_q == FULL_CNT);
   assign capture = (state_q == ST_IDLE) && kbd_int_req && !full;
   assign store   = capture && ((kbd_ascii != 8'h00) || !DROP_ZERO);
   assign wr_en   = store && !clr;
   assign pop     = rd_en && rd_valid_q && !clr;

   always_ff @(posedge clk or negedge rst_key) begin
      if (!rst_key) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (capture) state_d = ST_ACK;
         ST_ACK:  if (!kbd_int_req) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      kbd_int_ack = (state_q == ST_ACK);
      dbg_state_o = state_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // The head is registered; when the slot being written this edge becomes the
   // head, bypass the incoming byte since the array has not been updated yet.
   always_comb begin
      rd_valid_d = (count_d != '0);
      rd_data_d  = rd_data_q;
      if (rd_valid_d) begin
         if (wr_en && (rd_ptr_d == wr_ptr_q)) rd_data_d = kbd_ascii;
         else                                 rd_data_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= kbd_ascii;
   end

   always_ff @(posedge clk or negedge rst_key) begin
      if (!rst_key) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign cpu_irq  = rd_valid_q;
   assign count    = count_q;

   a_count_range: assert property (@(posedge clk) disable iff (!rst_key)
      count_q <= FULL_CNT);
   a_valid_matches_count: assert property (@(posedge clk) disable iff (!rst_key)
      rd_valid_q == (count_q != '0));

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: vector table, directed corner sequences, and random
// driver/CPU traffic scored against a queue model.
module tb_ps2_kbd_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           rst_key;
   logic [7:0]     kbd_ascii;
   logic           kbd_int_req;
   logic           kbd_int_ack;
   logic           rd_en;
   logic [7:0]     rd_data;
   logic           rd_valid;
   logic           cpu_irq;
   logic [DL2:0]   count;
   logic           clr;
   logic           dbg_state;

   logic [7:0]     kbd_ascii2;
   logic           kbd_int_req2;
   logic           kbd_int_ack2;
   logic           rd_en2;
   logic [7:0]     rd_data2;
   logic           rd_valid2;
   logic           cpu_irq2;
   logic [DL2:0]   count2;
   logic           clr2;
   logic           dbg_state2;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic       m_hs;

   typedef struct {
      logic       req;
      logic [7:0] ascii;
      logic       rd;
      logic       clr;
      logic       ack;
      logic [4:0] cnt;
      logic       valid;
      logic       chk_data;
      logic [7:0] data;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   ps2_kbd_fifo #(.DEPTH_LOG2(DL2), .DROP_ZERO(1'b1)) dut (
      .clk(clk), .rst_key(rst_key), .kbd_ascii(kbd_ascii), .kbd_int_req(kbd_int_req),
      .kbd_int_ack(kbd_int_ack), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .cpu_irq(cpu_irq), .count(count), .clr(clr), .dbg_state_o(dbg_state)
   );

   ps2_kbd_fifo #(.DEPTH_LOG2(DL2), .DROP_ZERO(1'b0)) dut_keep0 (
      .clk(clk), .rst_key(rst_key), .kbd_ascii(kbd_ascii2), .kbd_int_req(kbd_int_req2),
      .kbd_int_ack(kbd_int_ack2), .rd_en(rd_en2), .rd_data(rd_data2), .rd_valid(rd_valid2),
      .cpu_irq(cpu_irq2), .count(count2), .clr(clr2), .dbg_state_o(dbg_state2)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_key      = 1'b0;
      kbd_ascii    = 8'h00;
      kbd_int_req  = 1'b0;
      rd_en        = 1'b0;
      clr          = 1'b0;
      kbd_ascii2   = 8'h00;
      kbd_int_req2 = 1'b0;
      rd_en2       = 1'b0;
      clr2         = 1'b0;
      tick();
      tick();
      check("rst_ack",   kbd_int_ack, 0);
      check("rst_valid", rd_valid,    0);
      check("rst_irq",   cpu_irq,     0);
      check("rst_count", count,       0);
      check("rst_data",  rd_data,     0);
      check("rst_state", dbg_state,   0);
      rst_key = 1'b1;
      tick();
   endtask

   // driver: present one byte and complete the full handshake
   task automatic send_byte(input logic [7:0] b);
      int n;
      kbd_ascii   = b;
      kbd_int_req = 1'b1;
      n = 0;
      tick();
      while (!kbd_int_ack && n < 40) begin
         tick();
         n++;
      end
      check("send_ack_seen", kbd_int_ack, 1);
      kbd_int_req = 1'b0;
      tick();
      check("send_ack_drop", kbd_int_ack, 0);
   endtask

   task automatic init_vecs();
      //            req   ascii  rd    clr   ack   cnt   valid chk   data
      vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[2]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[3]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[4]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[5]  = '{1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h41};
      vecs[6]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 8'h41};
      vecs[7]  = '{1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 8'h41};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h42};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[14] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[15] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h66};
      vecs[16] = '{1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h66};
      vecs[17] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h77};
      vecs[18] = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h77};
   endtask

   task automatic apply_row(input int i);
      kbd_int_req = vecs[i].req;
      kbd_ascii   = vecs[i].ascii;
      rd_en       = vecs[i].rd;
      clr         = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_ack", i),   kbd_int_ack, vecs[i].ack);
      check($sformatf("vec%0d_count", i), count,       vecs[i].cnt);
      check($sformatf("vec%0d_valid", i), rd_valid,    vecs[i].valid);
      check($sformatf("vec%0d_irq", i),   cpu_irq,     vecs[i].valid);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rd_data, vecs[i].data);
   endtask

   // Reference: the FIFO is a byte queue; a req is taken once per assertion when
   // the queue had room before the edge; clr empties it and discards that edge's traffic.
   task automatic model_step();
      bit was_full;
      bit cap;
      was_full = (exp_q.size() == DEPTH);
      cap      = !m_hs && kbd_int_req && !was_full;
      if (clr) begin
         exp_q.delete();
      end else begin
         if (rd_en && exp_q.size() != 0) void'(exp_q.pop_front());
         if (cap && kbd_ascii != 8'h00) exp_q.push_back(kbd_ascii);
      end
      if (!m_hs) m_hs = cap;
      else       m_hs = kbd_int_req;
   endtask

   task automatic model_compare(input int cyc);
      check($sformatf("rnd%0d_count", cyc), count,       exp_q.size());
      check($sformatf("rnd%0d_valid", cyc), rd_valid,    exp_q.size() != 0);
      check($sformatf("rnd%0d_irq", cyc),   cpu_irq,     exp_q.size() != 0);
      check($sformatf("rnd%0d_ack", cyc),   kbd_int_ack, m_hs);
      if (exp_q.size() != 0) check($sformatf("rnd%0d_data", cyc), rd_data, exp_q[0]);
   endtask

   initial begin
      logic [7:0] e;
      int p_rd;

      // vector table
      do_reset();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_pop_count", count, 0);
      check("empty_pop_data",  rd_data, 8'h00);
      init_vecs();
      for (int i = 0; i < NV; i++) apply_row(i);

      // fill to full, backpressure, pop releases the held byte
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_byte(8'h61 + 8'(i));
      check("full_count", count, DEPTH);
      check("full_head",  rd_data, 8'h61);
      kbd_ascii   = 8'h71;
      kbd_int_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_noack",    kbd_int_ack, 0);
         check("full_hold_cnt", count, DEPTH);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("full_pop_data",  rd_data, 8'h62);
      check("full_pop_count", count, DEPTH - 1);
      check("full_pop_noack", kbd_int_ack, 0);
      tick();
      check("late_cap_ack",   kbd_int_ack, 1);
      check("late_cap_count", count, DEPTH);
      kbd_int_req = 1'b0;
      tick();
      check("late_cap_drop", kbd_int_ack, 0);
      for (int i = 0; i < DEPTH; i++) begin
         e = 8'h62 + 8'(i);
         check("drain_order", rd_data, e);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      check("drain_count", count, 0);
      check("drain_valid", rd_valid, 0);

      // zero byte kept when dropping is disabled
      kbd_ascii2   = 8'h00;
      kbd_int_req2 = 1'b1;
      tick();
      check("keep0_ack",   kbd_int_ack2, 1);
      check("keep0_state", dbg_state2, 1);
      check("keep0_count", count2, 1);
      check("keep0_valid", rd_valid2, 1);
      check("keep0_irq",   cpu_irq2, 1);
      check("keep0_data",  rd_data2, 8'h00);
      kbd_int_req2 = 1'b0;
      tick();
      check("keep0_drop",  kbd_int_ack2, 0);
      check("keep0_hold",  count2, 1);

      // flush with five entries
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
      check("clr_pre_count", count, 5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_count", count, 0);
      check("clr_valid", rd_valid, 0);
      check("clr_irq",   cpu_irq, 0);

      // reset during ACK, req still high afterwards
      do_reset();
      kbd_ascii   = 8'h5A;
      kbd_int_req = 1'b1;
      tick();
      check("mid_ack_up", kbd_int_ack, 1);
      check("mid_state",  dbg_state, 1);
      tick();
      #2;
      rst_key = 1'b0;
      #1;
      check("mid_rst_ack",   kbd_int_ack, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", rd_valid, 0);
      rst_key = 1'b1;
      tick();
      check("recap_ack",   kbd_int_ack, 1);
      check("recap_count", count, 1);
      check("recap_data",  rd_data, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("recap_once", count, 1);
      end
      kbd_int_req = 1'b0;
      tick();
      check("recap_drop", kbd_int_ack, 0);
      check("recap_keep", count, 1);

      // random driver / CPU traffic against the queue model
      do_reset();
      exp_q.delete();
      m_hs = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         p_rd = (cyc < 400) ? 5 : (cyc < 900) ? 70 : 30;
         if (!kbd_int_req && !m_hs) begin
            if ($urandom_range(3) != 0) begin
               kbd_int_req = 1'b1;
               kbd_ascii   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            end
         end else if (kbd_int_req && m_hs) begin
            if ($urandom_range(2) == 0) kbd_int_req = 1'b0;
         end
         rd_en = ($urandom_range(99) < p_rd);
         clr   = ($urandom_range(199) == 0);
         model_step();
         tick();
         model_compare(cyc);
      end
      kbd_int_req = 1'b0;
      rd_en       = 1'b0;
      clr         = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
